// File: rtl/soml_pkg.sv
// Shared definitions for the PAM minimum-distance slicer: default widths,
// controller state encoding and the constellation level generator.
package soml_pkg;

  localparam int SOML_N = 32;
  localparam int SOML_Q = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Level k of an m-ary PAM alphabet: (2k-(m-1)) scaled to q fractional bits.
  function automatic logic signed [63:0] level_val(input int k, input int m, input int q);
    logic signed [63:0] step;
    step = 64'(2 * k - (m - 1));
    return step <<< q;
  endfunction

endpackage

// File: rtl/pam_min_slicer_dist_sq.sv
// Squared distance between one sample and one level, rescaled to Q format.
// Both the full-precision and the saturated N-bit result are provided.
module dist_sq
  import soml_pkg::*;
#(
  parameter int N = SOML_N,
  parameter int Q = SOML_Q
) (
  input  logic signed [N-1:0]   x_i,
  input  logic signed [N:0]     lvl_i,
  output logic        [2*N+1:0] d_full_o,
  output logic        [N-1:0]   d_sat_o
);

  localparam logic [2*N+1:0] SAT_MAX = {{(N + 3){1'b0}}, {(N - 1){1'b1}}};

  logic signed [N:0]     diff_s;
  logic signed [2*N+1:0] diff_w_s;
  logic signed [2*N+1:0] prod_s;
  logic signed [2*N+1:0] shr_s;

  assign diff_s   = {x_i[N-1], x_i} - lvl_i;
  assign diff_w_s = {{(N + 1){diff_s[N]}}, diff_s};
  assign prod_s   = diff_w_s * diff_w_s;
  assign shr_s    = prod_s >>> Q;
  assign d_full_o = shr_s;

  always_comb begin
    if (d_full_o > SAT_MAX) begin
      d_sat_o = {1'b0, {(N - 1){1'b1}}};
    end else begin
      d_sat_o = d_full_o[N-1:0];
    end
  end

endmodule

// File: rtl/pam_min_slicer.sv
// Multi-channel PAM slicer: sweeps all M levels, one per cycle, and keeps
// the per-channel nearest level, its distance and the sum of distances.
module pam_min_slicer
  import soml_pkg::*;
#(
  parameter int N  = SOML_N,
  parameter int Q  = SOML_Q,
  parameter int CH = 4,
  parameter int M  = 4,
  parameter int IW = ($clog2(M) > 1) ? $clog2(M) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH*N-1:0]             x_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH*N-1:0]             min_dist,
  output logic [CH*IW-1:0]            min_idx,
  output logic [N+$clog2(CH)-1:0]     dist_sum
);

  localparam int SW = N + $clog2(CH);

  state_e              state_q;
  logic [IW-1:0]       k_q;
  logic [CH*N-1:0]     x_q;
  logic [2*N+1:0]      best_q [CH];
  logic [CH*N-1:0]     min_dist_q;
  logic [CH*IW-1:0]    min_idx_q;
  logic [SW-1:0]       dist_sum_q;
  logic                out_valid_q;

  logic signed [N:0]   lvl_s;
  logic [2*N+1:0]      d_full_s [CH];
  logic [N-1:0]        d_sat_s [CH];
  logic [N-1:0]        min_next_s [CH];
  logic [CH-1:0]       take_s;
  logic [SW-1:0]       sum_s;
  logic                accept_s;

  assign lvl_s    = (N + 1)'(level_val(int'(k_q), M, Q));
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s = in_valid && in_ready;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    dist_sq #(.N(N), .Q(Q)) u_dist (
      .x_i      (x_q[g*N +: N]),
      .lvl_i    (lvl_s),
      .d_full_o (d_full_s[g]),
      .d_sat_o  (d_sat_s[g])
    );
  end

  // Minimum tracking compares full-precision distances so that saturated
  // candidates still resolve to the truly nearest level.
  always_comb begin
    sum_s = '0;
    for (int c = 0; c < CH; c++) begin
      if ((k_q == '0) || (d_full_s[c] < best_q[c])) begin
        take_s[c] = 1'b1;
      end else begin
        take_s[c] = 1'b0;
      end
      if (take_s[c]) begin
        min_next_s[c] = d_sat_s[c];
      end else begin
        min_next_s[c] = min_dist_q[c*N +: N];
      end
      sum_s = sum_s + SW'(min_next_s[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      x_q         <= '0;
      min_dist_q  <= '0;
      min_idx_q   <= '0;
      dist_sum_q  <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < CH; c++) best_q[c] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            x_q     <= x_in;
            k_q     <= '0;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          for (int c = 0; c < CH; c++) begin
            if (take_s[c]) begin
              best_q[c]               <= d_full_s[c];
              min_dist_q[c*N +: N]    <= d_sat_s[c];
              min_idx_q[c*IW +: IW]   <= k_q;
            end
          end
          if (k_q == IW'(M - 1)) begin
            k_q         <= '0;
            dist_sum_q  <= sum_s;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            k_q <= k_q + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              x_q     <= x_in;
              k_q     <= '0;
              state_q <= ST_SWEEP;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign min_dist  = min_dist_q;
  assign min_idx   = min_idx_q;
  assign dist_sum  = dist_sum_q;

endmodule
